cla_nibble_seq_ctrl: RTL and testbench

//  Multi-cycle controller that time-shares one 4-bit carry-lookahead slice to add WIDTH-bit operands.

---
 rtl/cla_nibble_seq_ctrl_if.sv | 24 ++
 rtl/cla_nibble_seq_ctrl.sv | 117 +++++++++++
 tb/tb_cla_nibble_seq_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/cla_nibble_seq_ctrl_if.sv
// Start/Done handshake and operand/result bus between the datapath and cla_nibble_seq_ctrl.
interface cla_nibble_seq_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             Start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             Sub;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Sum;
    logic             Cout;

    modport master (
        output Start, A, B, Cin, Sub,
        input  Busy, Done, Sum, Cout
    );

    modport slave (
        input  Start, A, B, Cin, Sub,
        output Busy, Done, Sum, Cout
    );
endinterface

// File: rtl/cla_nibble_seq_ctrl.sv
// Time-shares one external 4-bit lookahead slice to add WIDTH-bit operands, one nibble per cycle.
// Optional subtract mode is enabled by defining CLA_SEQ_SUBTRACT_EN.
//
// state | meaning
// IDLE  | waiting for Start, slice inputs forced to 0
// RUN   | feeding nibble k to the slice, capturing its result
// DONE  | one-cycle result pulse; Start here chains the next operation
module cla_nibble_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    cla_nibble_seq_ctrl_if.slave bus,
    output logic [3:0]           slice_C,
    output logic [3:0]           slice_D,
    output logic                 slice_cin,
    input  logic [3:0]           slice_T,
    input  logic                 slice_cout
);
    localparam int NIB = WIDTH / 4;
    localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sum_r;
    logic             carry_r;
    logic             cout_r;
    logic             busy_r;
    logic             done_r;
    logic [KW-1:0]    k;

    logic [KW+1:0]    base;
    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [3:0]       d_nib;
    logic             init_carry;

    assign base  = {k, 2'b00};
    assign a_nib = a_r[base +: 4];
    assign b_nib = b_r[base +: 4];

`ifdef CLA_SEQ_SUBTRACT_EN
    logic sub_r;
    // Two's-complement subtract: invert B and force the initial carry to 1.
    assign d_nib      = sub_r ? ~b_nib : b_nib;
    assign init_carry = bus.Sub ? 1'b1 : bus.Cin;
`else
    assign d_nib      = b_nib;
    assign init_carry = bus.Cin;
`endif

    assign slice_C   = (state == RUN) ? a_nib   : 4'h0;
    assign slice_D   = (state == RUN) ? d_nib   : 4'h0;
    assign slice_cin = (state == RUN) ? carry_r : 1'b0;

    assign bus.Busy = busy_r;
    assign bus.Done = done_r;
    assign bus.Sum  = sum_r;
    assign bus.Cout = cout_r;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            k       <= '0;
`ifdef CLA_SEQ_SUBTRACT_EN
            sub_r   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (bus.Start) begin
                        a_r     <= bus.A;
                        b_r     <= bus.B;
                        carry_r <= init_carry;
                        k       <= '0;
`ifdef CLA_SEQ_SUBTRACT_EN
                        sub_r   <= bus.Sub;
`endif
                        busy_r  <= 1'b1;
                        state   <= RUN;
                    end else begin
                        busy_r  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                RUN: begin
                    sum_r[base +: 4] <= slice_T;
                    carry_r          <= slice_cout;
                    k                <= k + 1'b1;
                    if (k == K_LAST) begin
                        cout_r <= slice_cout;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cla_nibble_seq_ctrl.sv
// Self-checking bench for cla_nibble_seq_ctrl with a behavioural 4-bit slice and arithmetic reference model.
module tb_cla_nibble_seq_ctrl;
    localparam int W = 16;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [3:0] slice_C, slice_D, slice_T;
    logic       slice_cin, slice_cout;

    int checks   = 0;
    int failures = 0;

    cla_nibble_seq_ctrl_if #(.WIDTH(W)) bus();

    cla_nibble_seq_ctrl #(.WIDTH(W)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .bus       (bus),
        .slice_C   (slice_C),
        .slice_D   (slice_D),
        .slice_cin (slice_cin),
        .slice_T   (slice_T),
        .slice_cout(slice_cout)
    );

    // external lookahead slice: plain 4-bit add
    assign {slice_cout, slice_T} = {1'b0, slice_C} + {1'b0, slice_D} + {4'b0, slice_cin};

    always #5 Clk = ~Clk;

    typedef struct {
        string       name;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [16:0] ref_op(input logic [15:0] a, input logic [15:0] b,
                                           input logic cin, input logic sub);
`ifdef CLA_SEQ_SUBTRACT_EN
        if (sub) return {1'b0, a} + {1'b0, ~b} + 17'd1;
`endif
        return {1'b0, a} + {1'b0, b} + {16'd0, cin};
    endfunction

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic sub, output int lat, output int busy_cnt);
        @(negedge Clk);
        bus.A = a; bus.B = b; bus.Cin = cin; bus.Sub = sub; bus.Start = 1'b1;
        @(negedge Clk);
        bus.Start = 1'b0;
        lat = 1;
        busy_cnt = 0;
        while (!bus.Done && lat < 20) begin
            if (bus.Busy) busy_cnt++;
            @(negedge Clk);
            lat++;
        end
    endtask

    initial begin
        int lat, bcnt, pulses, last_pulse;
        logic [16:0] r;
        logic [15:0] ra, rb;
        logic rc, rs;
        logic seen;

        vecs[0] = '{"add_basic",   16'h1234, 16'h0F0F, 1'b0, 1'b0, 16'h2143, 1'b0};
        vecs[1] = '{"ripple_all",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{"ripple_cin",  16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1};
        vecs[3] = '{"zero",        16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0};
`ifdef CLA_SEQ_SUBTRACT_EN
        vecs[4] = '{"sub_borrow",  16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0};
        vecs[5] = '{"sub_noborrow",16'h0009, 16'h0003, 1'b0, 1'b1, 16'h0006, 1'b1};
`else
        vecs[4] = '{"sub_ignored", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'h000C, 1'b0};
        vecs[5] = '{"sub_ignored2",16'h0009, 16'h0003, 1'b0, 1'b1, 16'h000C, 1'b0};
`endif

        Reset = 1'b1;
        bus.Start = 1'b0; bus.A = '0; bus.B = '0; bus.Cin = 1'b0; bus.Sub = 1'b0;
        repeat (2) @(negedge Clk);
        chk("rst_busy", 32'(bus.Busy), 32'd0);
        chk("rst_done", 32'(bus.Done), 32'd0);
        chk("rst_sum",  32'(bus.Sum),  32'd0);
        chk("rst_cout", 32'(bus.Cout), 32'd0);
        chk("rst_slice_c",   32'(slice_C),   32'd0);
        chk("rst_slice_d",   32'(slice_D),   32'd0);
        chk("rst_slice_cin", 32'(slice_cin), 32'd0);
        Reset = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, lat, bcnt);
            chk({vecs[i].name, "_latency"}, 32'(lat), 32'd5);
            chk({vecs[i].name, "_busy"}, 32'(bcnt), 32'd4);
            chk({vecs[i].name, "_sum"}, 32'(bus.Sum), 32'(vecs[i].sum));
            chk({vecs[i].name, "_cout"}, 32'(bus.Cout), 32'(vecs[i].cout));
            chk({vecs[i].name, "_slice_idle"}, 32'({slice_C, slice_D, slice_cin}), 32'd0);
            @(negedge Clk);
            chk({vecs[i].name, "_done_pulse"}, 32'(bus.Done), 32'd0);
            chk({vecs[i].name, "_sum_hold"}, 32'(bus.Sum), 32'(vecs[i].sum));
        end

        // Start held high: Done must pulse every 5 cycles, never restart mid-run
        @(negedge Clk);
        bus.A = 16'h0001; bus.B = 16'h0001; bus.Cin = 1'b0; bus.Sub = 1'b0; bus.Start = 1'b1;
        pulses = 0;
        last_pulse = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge Clk);
            if (bus.Done) begin
                pulses++;
                chk("b2b_pulse_spacing", 32'(i - last_pulse), 32'd5);
                chk("b2b_sum", 32'(bus.Sum), 32'h0002);
                last_pulse = i;
            end
        end
        chk("b2b_pulse_count", 32'(pulses), 32'd2);
        bus.Start = 1'b0;
        lat = 0;
        while (!bus.Done && lat < 20) begin
            @(negedge Clk);
            lat++;
        end
        chk("b2b_final_done", 32'(bus.Done), 32'd1);
        chk("b2b_final_sum", 32'(bus.Sum), 32'h0002);
        @(negedge Clk);
        chk("b2b_idle_busy", 32'(bus.Busy), 32'd0);
        chk("b2b_idle_done", 32'(bus.Done), 32'd0);

        // Reset in 3rd RUN cycle aborts the operation
        @(negedge Clk);
        bus.A = 16'h3333; bus.B = 16'h1111; bus.Start = 1'b1;
        @(negedge Clk);
        bus.Start = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        chk("abort_busy", 32'(bus.Busy), 32'd0);
        chk("abort_done", 32'(bus.Done), 32'd0);
        chk("abort_sum",  32'(bus.Sum),  32'd0);
        Reset = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge Clk);
            if (bus.Done) seen = 1'b1;
        end
        chk("abort_no_done", 32'(seen), 32'd0);
        run_op(16'h3333, 16'h1111, 1'b0, 1'b0, lat, bcnt);
        chk("abort_rerun_latency", 32'(lat), 32'd5);
        chk("abort_rerun_sum", 32'(bus.Sum), 32'h4444);

        // randomized operations against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            r = ref_op(ra, rb, rc, rs);
            run_op(ra, rb, rc, rs, lat, bcnt);
            chk("rand_latency", 32'(lat), 32'd5);
            chk("rand_sum", 32'(bus.Sum), 32'(r[15:0]));
            chk("rand_cout", 32'(bus.Cout), 32'(r[16]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
